comma_align_sync: RTL

COMMA_ALIGN_SYNC -- requirements
Module: comma_align_sync

---
 rtl/comma_align_pkg.sv | 25 ++
 rtl/sym_phase_cnt.sv | 42 ++++
 rtl/comma_align_sync.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/comma_align_pkg.sv
// ============================================================================
// Module  : comma_align_pkg
// Brief   : Shared state encoding, comma constants and comma matcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

package comma_align_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COMMA = 2'b01,
    DATA  = 2'b10
  } state_e;

  localparam logic [9:0] COMMA_P = 10'h0FA;
  localparam logic [9:0] COMMA_N = 10'h305;

  function automatic logic is_comma(input logic [9:0] sym);
    return (sym == COMMA_P) || (sym == COMMA_N);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sym_phase_cnt.sv
// ============================================================================
// Module  : sym_phase_cnt
// Brief   : Symbol phase counter; returns to zero on restart or wrap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sym_phase_cnt #(
  parameter int SYM_CYCLES = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          restart,
  input  logic                          wrap,
  output logic [$clog2(SYM_CYCLES)-1:0] phase
);

  localparam int W = $clog2(SYM_CYCLES);

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q + 1'b1;
    if (restart || wrap) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/comma_align_sync.sv
// ============================================================================
// Module  : comma_align_sync
// Brief   : Comma-based symbol alignment and lock FSM (IDLE/COMMA/DATA).
//           Optional statistics counters enabled by COMMA_ALIGN_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module comma_align_sync
  import comma_align_pkg::*;
#(
  parameter int COMMA_NUMBER   = 4,
  parameter int SYM_CYCLES     = 10,
  parameter int LOSS_THRESHOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] data,
  input  logic       sym_err,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  output logic       comma_pulse,
  output logic       locked,
  output logic       sync_lost,
  output logic       count_rst
`ifdef COMMA_ALIGN_STATS_EN
  ,
  output logic [15:0] lock_loss_cnt,
  output logic [15:0] comma_seen_cnt
`endif
);

  localparam int              PW         = $clog2(SYM_CYCLES);
  localparam logic [PW-1:0]   PHASE_LAST = PW'(SYM_CYCLES - 1);
  localparam logic [4:0]      COMMA_LAST = 5'(COMMA_NUMBER - 1);
  localparam logic [3:0]      ERR_LAST   = 4'(LOSS_THRESHOLD - 1);

  state_e       state_q, state_d;
  logic [4:0]   comma_cnt_q, comma_cnt_d;
  logic [3:0]   err_cnt_q, err_cnt_d;
  logic [9:0]   rx_data_q, rx_data_d;
  logic         rx_valid_q, rx_valid_d;
  logic         comma_pulse_q, comma_pulse_d;
  logic         sync_lost_q, sync_lost_d;

  logic [PW-1:0] phase;
  logic          eval;
  logic          sym_is_comma;
  logic          good_comma;
  logic          restart;

  assign eval         = (phase == PHASE_LAST);
  assign sym_is_comma = is_comma(data);
  assign good_comma   = sym_is_comma && !sym_err;

  // Phase realigns whenever we move into an alignment or locked state.
  assign restart   = (state_d != state_q) && (state_d != IDLE);
  assign count_rst = restart && rst_n;

  sym_phase_cnt #(
    .SYM_CYCLES(SYM_CYCLES)
  ) u_phase (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .wrap   (eval),
    .phase  (phase)
  );

  always_comb begin
    state_d       = state_q;
    comma_cnt_d   = comma_cnt_q;
    err_cnt_d     = err_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    comma_pulse_d = 1'b0;
    sync_lost_d   = 1'b0;

    case (state_q)
      IDLE: begin
        comma_cnt_d = '0;
        err_cnt_d   = '0;
        if (good_comma) begin
          state_d     = COMMA;
          comma_cnt_d = 5'd1;
        end
      end

      COMMA: begin
        if (eval) begin
          if (!good_comma) begin
            state_d     = IDLE;
            comma_cnt_d = '0;
          end else if (comma_cnt_q == COMMA_LAST) begin
            state_d     = DATA;
            comma_cnt_d = '0;
            err_cnt_d   = '0;
          end else begin
            comma_cnt_d = comma_cnt_q + 5'd1;
          end
        end
      end

      DATA: begin
        if (eval) begin
          if (sym_err) begin
            if (err_cnt_q == ERR_LAST) begin
              state_d     = IDLE;
              sync_lost_d = 1'b1;
              err_cnt_d   = '0;
            end else begin
              err_cnt_d = err_cnt_q + 4'd1;
            end
          end else begin
            rx_data_d     = data;
            rx_valid_d    = 1'b1;
            comma_pulse_d = sym_is_comma;
            err_cnt_d     = '0;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        comma_cnt_d = '0;
        err_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      comma_cnt_q   <= '0;
      err_cnt_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      comma_pulse_q <= 1'b0;
      sync_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      comma_cnt_q   <= comma_cnt_d;
      err_cnt_q     <= err_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      comma_pulse_q <= comma_pulse_d;
      sync_lost_q   <= sync_lost_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign comma_pulse = comma_pulse_q;
  assign sync_lost   = sync_lost_q;
  assign locked      = (state_q == DATA);

`ifdef COMMA_ALIGN_STATS_EN
  logic [15:0] lock_loss_cnt_q, lock_loss_cnt_d;
  logic [15:0] comma_seen_cnt_q, comma_seen_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    lock_loss_cnt_d  = lock_loss_cnt_q;
    comma_seen_cnt_d = comma_seen_cnt_q;
    if (sync_lost_q && (lock_loss_cnt_q != 16'hFFFF)) begin
      lock_loss_cnt_d = lock_loss_cnt_q + 16'd1;
    end
    if (comma_pulse_q && (comma_seen_cnt_q != 16'hFFFF)) begin
      comma_seen_cnt_d = comma_seen_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt_q  <= '0;
      comma_seen_cnt_q <= '0;
    end else begin
      lock_loss_cnt_q  <= lock_loss_cnt_d;
      comma_seen_cnt_q <= comma_seen_cnt_d;
    end
  end

  assign lock_loss_cnt  = lock_loss_cnt_q;
  assign comma_seen_cnt = comma_seen_cnt_q;
`endif

endmodule

`default_nettype wire
